lcd_nibble_receiver: RTL and testbench

- Synthesizable receiver/decoder for the 4-bit character-LCD bus (sf_e, e, rs, rw, d, c, b, a) that our LCD print block drives.
- Plays the LCD-controller side: captures nibbles on falling e, tracks the 8-bit init and 4-bit mode switch, assembles bytes, and decodes commands.
- Keeps a small display RAM that the bench and the on-board self-check read, so ALU result printing is checked without a physical panel.

---
 rtl/lcd_nibble_receiver_if.sv | 15 +
 rtl/lcd_nibble_receiver.sv | 147 ++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_nibble_receiver_if.sv
// rtl/lcd_nibble_receiver_if.sv - 4-bit character-LCD bus as driven by the print block
// The print block is the master; the receiver/decoder observes the bus as slave.
interface lcd_nibble_receiver_if;
   logic sf_e;
   logic e;
   logic rs;
   logic rw;
   logic d;
   logic c;
   logic b;
   logic a;

   modport master (output sf_e, e, rs, rw, d, c, b, a);
   modport slave  (input  sf_e, e, rs, rw, d, c, b, a);
endinterface

// File: rtl/lcd_nibble_receiver.sv
// rtl/lcd_nibble_receiver.sv - LCD-controller-side nibble receiver, command decoder and display RAM
// Nibbles are taken on the falling edge of e using the bus values held while e was high.
module lcd_nibble_receiver #(
   parameter int          AW       = 4,
   parameter logic [7:0]  CLR_CHAR = 8'h20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lcd_nibble_receiver_if.slave lcd,
   input  logic [AW-1:0]        rd_addr,
   output logic [7:0]           rd_data,
   output logic                 char_valid,
   output logic [7:0]           char_data,
   output logic [AW-1:0]        char_addr,
   output logic                 cmd_valid,
   output logic [7:0]           cmd_byte,
   output logic                 mode_4bit,
   output logic                 disp_on,
   output logic [AW-1:0]        cur_addr,
   output logic                 busy,
   output logic                 proto_err
);
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} state_t;

   state_t          state;
   logic            e_q;
   logic [5:0]      bus_q;
   logic [3:0]      hi_nib;
   logic            hi_rs;
   logic            dir_inc;
   logic [AW-1:0]   sweep_addr;
   logic [7:0]      mem [DEPTH];

   logic            strobe;
   logic            rs_q;
   logic            rw_q;
   logic [3:0]      nib_q;
   logic [7:0]      byte_v;
   logic            wr_data;

   assign strobe  = e_q & ~lcd.e & lcd.sf_e;
   assign {rs_q, rw_q, nib_q} = bus_q;
   assign byte_v  = {hi_nib, nib_q};
   assign wr_data = strobe && !rw_q && !busy && (state == NIB_LO) && hi_rs && rs_q;

   // Sweep and data writes never coincide: strobes are refused while busy.
   always_ff @(posedge clk) begin
      if (rst_n && busy) begin
         mem[sweep_addr] <= CLR_CHAR;
      end else if (rst_n && wr_data) begin
         mem[cur_addr] <= byte_v;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_q        <= 1'b0;
         bus_q      <= '0;
         state      <= INIT8;
         hi_nib     <= '0;
         hi_rs      <= 1'b0;
         dir_inc    <= 1'b1;
         sweep_addr <= '0;
         busy       <= 1'b1;
         rd_data    <= '0;
         char_valid <= 1'b0;
         char_data  <= '0;
         char_addr  <= '0;
         cmd_valid  <= 1'b0;
         cmd_byte   <= '0;
         mode_4bit  <= 1'b0;
         disp_on    <= 1'b0;
         cur_addr   <= '0;
         proto_err  <= 1'b0;
      end else begin
         e_q        <= lcd.e;
         bus_q      <= {lcd.rs, lcd.rw, lcd.d, lcd.c, lcd.b, lcd.a};
         rd_data    <= mem[rd_addr];
         char_valid <= 1'b0;
         cmd_valid  <= 1'b0;
         proto_err  <= 1'b0;

         if (busy) begin
            sweep_addr <= sweep_addr + 1'b1;
            if (sweep_addr == AW'(DEPTH - 1)) busy <= 1'b0;
         end

         if (strobe && !rw_q) begin
            if (busy) begin
               proto_err <= 1'b1;
            end else begin
               case (state)
                  INIT8: begin
                     if (nib_q == 4'h2) begin
                        state     <= NIB_HI;
                        mode_4bit <= 1'b1;
                     end else if (nib_q != 4'h3) begin
                        proto_err <= 1'b1;
                     end
                  end
                  NIB_HI: begin
                     hi_nib <= nib_q;
                     hi_rs  <= rs_q;
                     state  <= NIB_LO;
                  end
                  default: begin
                     state <= NIB_HI;
                     if (hi_rs != rs_q) begin
                        proto_err <= 1'b1;
                     end else if (rs_q) begin
                        char_valid <= 1'b1;
                        char_data  <= byte_v;
                        char_addr  <= cur_addr;
                        cur_addr   <= dir_inc ? cur_addr + 1'b1 : cur_addr - 1'b1;
                     end else begin
                        cmd_valid <= 1'b1;
                        cmd_byte  <= byte_v;
                        if (byte_v == 8'h01) begin
                           cur_addr   <= '0;
                           dir_inc    <= 1'b1;
                           busy       <= 1'b1;
                           sweep_addr <= '0;
                        end else if (byte_v[7:1] == 7'b0000001) begin
                           cur_addr <= '0;
                        end else if (byte_v[7:2] == 6'b000001) begin
                           dir_inc <= byte_v[1];
                        end else if (byte_v[7:3] == 5'b00001) begin
                           disp_on <= byte_v[2];
                        end else if (byte_v[7:5] == 3'b001) begin
                           // DL=1 means the host is restarting the 3,3,3,2 wake-up sequence.
                           if (byte_v[4]) begin
                              state     <= INIT8;
                              mode_4bit <= 1'b0;
                           end
                        end else if (byte_v[7]) begin
                           cur_addr <= byte_v[AW-1:0];
                        end
                     end
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb/tb_lcd_nibble_receiver.sv - directed plus randomized bench for lcd_nibble_receiver
// Expected values come from a behavioural model of the LCD controller kept in this bench.
module tb_lcd_nibble_receiver;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rd_addr = 4'd0;
   logic [7:0] rd_data;
   logic       char_valid;
   logic [7:0] char_data;
   logic [3:0] char_addr;
   logic       cmd_valid;
   logic [7:0] cmd_byte;
   logic       mode_4bit;
   logic       disp_on;
   logic [3:0] cur_addr;
   logic       busy;
   logic       proto_err;

   always #10 clk = ~clk;

   lcd_nibble_receiver_if bus ();

   lcd_nibble_receiver #(.AW(4), .CLR_CHAR(8'h20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lcd        (bus),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_addr  (char_addr),
      .cmd_valid  (cmd_valid),
      .cmd_byte   (cmd_byte),
      .mode_4bit  (mode_4bit),
      .disp_on    (disp_on),
      .cur_addr   (cur_addr),
      .busy       (busy),
      .proto_err  (proto_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]  ram_m [16];
   logic [3:0]  cur_m;
   logic [3:0]  hi_m;
   bit          dir_m, mode_m, disp_m, have_hi, hi_rs_m, busy_m;
   logic [7:0]  exp_cmd[$], got_cmd[$];
   logic [11:0] exp_char[$], got_char[$];
   int          exp_err = 0;
   int          got_err = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid)  got_cmd.push_back(cmd_byte);
         if (char_valid) got_char.push_back({char_addr, char_data});
         if (proto_err)  got_err++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ram_m[i] = 8'h20;
      cur_m = 4'd0; dir_m = 1'b1; mode_m = 1'b0; disp_m = 1'b0;
      have_hi = 1'b0; busy_m = 1'b1;
   endtask

   task automatic model_exec(input bit rs, input logic [7:0] bv);
      if (rs) begin
         ram_m[cur_m] = bv;
         exp_char.push_back({cur_m, bv});
         cur_m = dir_m ? 4'(cur_m + 1) : 4'(cur_m + 15);
      end else begin
         exp_cmd.push_back(bv);
         if (bv == 8'h01) begin
            for (int i = 0; i < 16; i++) ram_m[i] = 8'h20;
            cur_m = 4'd0; dir_m = 1'b1; busy_m = 1'b1;
         end
         else if (bv inside {[8'h02:8'h03]}) cur_m = 4'd0;
         else if (bv inside {[8'h04:8'h07]}) dir_m = bv[1];
         else if (bv inside {[8'h08:8'h0F]}) disp_m = bv[2];
         else if (bv inside {[8'h20:8'h3F]}) begin
            if (bv[4]) mode_m = 1'b0;
         end
         else if (bv >= 8'h80) cur_m = bv[3:0];
      end
   endtask

   task automatic model_nib(input bit sf, input bit rs, input bit rw, input logic [3:0] n);
      if (!sf || rw) return;
      if (busy_m) begin
         exp_err++;
         return;
      end
      if (!mode_m) begin
         if (n == 4'h2) begin mode_m = 1'b1; have_hi = 1'b0; end
         else if (n != 4'h3) exp_err++;
      end else if (!have_hi) begin
         hi_m = n; hi_rs_m = rs; have_hi = 1'b1;
      end else begin
         have_hi = 1'b0;
         if (hi_rs_m != rs) exp_err++;
         else model_exec(rs, {hi_m, n});
      end
   endtask

   task automatic send_nib(input bit sf, input bit rs, input bit rw, input logic [3:0] n);
      @(negedge clk);
      bus.sf_e = sf; bus.rs = rs; bus.rw = rw;
      {bus.d, bus.c, bus.b, bus.a} = n;
      bus.e = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.e = 1'b0;
      @(negedge clk);
   endtask

   task automatic nib(input bit sf, input bit rs, input bit rw, input logic [3:0] n);
      model_nib(sf, rs, rw, n);
      send_nib(sf, rs, rw, n);
   endtask

   task automatic byte_w(input bit rs, input logic [7:0] bv);
      nib(1'b1, rs, 1'b0, bv[7:4]);
      nib(1'b1, rs, 1'b0, bv[3:0]);
   endtask

   task automatic wait_clear(input bit chk_len);
      int cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      if (chk_len) check("busy_len", cnt, 16);
      check("busy_end", busy, 1'b0);
      busy_m = 1'b0;
   endtask

   task automatic check_ram(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, i), rd_data, ram_m[i]);
      end
   endtask

   task automatic cmp_queues(input string tag);
      check({tag, "_ncmd"}, got_cmd.size(), exp_cmd.size());
      for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++)
         check($sformatf("%s_cmd%0d", tag, i), got_cmd[i], exp_cmd[i]);
      check({tag, "_nchar"}, got_char.size(), exp_char.size());
      for (int i = 0; i < got_char.size() && i < exp_char.size(); i++)
         check($sformatf("%s_char%0d", tag, i), got_char[i], exp_char[i]);
      check({tag, "_perr"}, got_err, exp_err);
      got_cmd.delete(); exp_cmd.delete(); got_char.delete(); exp_char.delete();
      got_err = 0; exp_err = 0;
   endtask

   task automatic do_reset(input bit chk_state);
      bus.e = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      if (chk_state) begin
         check("rst_mode", mode_4bit, 1'b0);
         check("rst_cur", cur_addr, 4'd0);
         check("rst_cmd", {cmd_valid, cmd_byte}, 9'd0);
         check("rst_char", {char_valid, char_addr, char_data}, 13'd0);
         check("rst_rd", rd_data, 8'd0);
         check("rst_misc", {disp_on, proto_err}, 2'd0);
      end
      rst_n = 1'b1;
      model_reset();
      wait_clear(1'b1);
   endtask

   logic [7:0] cb;

   initial begin
      bus.sf_e = 1'b1; bus.e = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0;
      bus.d = 1'b0; bus.c = 1'b0; bus.b = 1'b0; bus.a = 1'b0;

      do_reset(1'b1);
      check_ram("ram_rst");

      nib(1, 0, 0, 4'h3); nib(1, 0, 0, 4'h3); nib(1, 0, 0, 4'h3);
      check("init8_mode", mode_4bit, 1'b0);
      nib(1, 0, 0, 4'h2);
      check("mode4_on", mode_4bit, 1'b1);
      byte_w(0, 8'h28); byte_w(0, 8'h06); byte_w(0, 8'h0C); byte_w(0, 8'h01);
      wait_clear(1'b1);
      check("disp_on", disp_on, disp_m);
      cmp_queues("init");

      byte_w(1, 8'h35);
      check("d35_data", char_data, 8'h35);
      check("d35_addr", char_addr, 4'd0);
      check("d35_cur", cur_addr, 4'd1);
      nib(1, 1, 0, 4'h4);
      repeat (50) nib(1, 0, 1, 4'h0);
      nib(1, 1, 0, 4'h1);
      check("d41_data", char_data, 8'h41);
      check("d41_addr", char_addr, 4'd1);
      check_ram("ram_data");
      cmp_queues("data");

      byte_w(0, 8'h33);
      check("reinit_mode", mode_4bit, 1'b0);
      nib(1, 0, 0, 4'h3); nib(1, 0, 0, 4'h2);
      check("reinit_mode4", mode_4bit, 1'b1);
      cmp_queues("reinit");

      byte_w(0, 8'h8F);
      repeat (3) byte_w(1, 8'($urandom));
      check("wrap_cur", cur_addr, cur_m);
      check_ram("ram_wrap");
      cmp_queues("wrap");

      byte_w(0, 8'h01);
      nib(1, 1, 0, 4'h7);
      wait_clear(1'b0);
      check_ram("ram_clr");
      cmp_queues("busy");

      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: byte_w(1, 8'($urandom));
            6: begin
               case ($urandom_range(0, 4))
                  0: cb = 8'h04 + 8'($urandom_range(0, 3));
                  1: cb = 8'h08 + 8'($urandom_range(0, 7));
                  2: cb = 8'h80 | 8'($urandom);
                  3: cb = 8'h02 + 8'($urandom_range(0, 1));
                  default: cb = 8'h10 + 8'($urandom_range(0, 31));
               endcase
               byte_w(0, cb);
            end
            7: begin
               nib(1, 0, 0, 4'($urandom));
               nib(1, 1, 0, 4'($urandom));
            end
            8: repeat ($urandom_range(1, 5)) nib(1, 1'($urandom), 1, 4'($urandom));
            default: nib(0, 1'($urandom), 0, 4'($urandom));
         endcase
      end
      check("rand_cur", cur_addr, cur_m);
      check("rand_disp", disp_on, disp_m);
      check("rand_mode", mode_4bit, mode_m);
      check_ram("ram_rand");
      cmp_queues("rand");

      nib(1, 1, 0, 4'h4);
      do_reset(1'b0);
      check("midrst_mode", mode_4bit, 1'b0);
      nib(1, 0, 0, 4'h5);
      nib(1, 0, 0, 4'h2);
      byte_w(1, 8'h5A);
      check("midrst_data", char_data, 8'h5A);
      check("midrst_addr", char_addr, 4'd0);
      check_ram("ram_midrst");
      cmp_queues("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
